// File: rtl/pad_seq_pkg.sv
// pad_seq_pkg: shared types for the glitch-free pad mux sequencer.
package pad_seq_pkg;
   localparam int PAD_CFG_W = 6;
   typedef logic [PAD_CFG_W-1:0] pad_cfg_t;
   typedef enum logic [1:0] {IDLE, GATE, APPLY, RELEASE} seq_state_e;
endpackage

// File: rtl/pad_change_detect.sv
// pad_change_detect: flags every pad whose requested mux bit or config differs from the applied one.
module pad_change_detect
   import pad_seq_pkg::*;
#(
   parameter int N_PADS = 32
) (
   input  logic     [N_PADS-1:0] req_mux_i,
   input  pad_cfg_t [N_PADS-1:0] req_cfg_i,
   input  logic     [N_PADS-1:0] cur_mux_i,
   input  pad_cfg_t [N_PADS-1:0] cur_cfg_i,
   output logic     [N_PADS-1:0] mask_o
);
   always_comb begin
      mask_o = '0;
      for (int i = 0; i < N_PADS; i++)
         mask_o[i] = (req_mux_i[i] != cur_mux_i[i]) | (req_cfg_i[i] != cur_cfg_i[i]);
   end
endmodule

// File: rtl/pad_mux_sequencer.sv
// pad_mux_sequencer: applies pad mux/config changes glitch-free by gating the affected pads
// for a settle period before and after the switch.
module pad_mux_sequencer
   import pad_seq_pkg::*;
#(
   parameter int N_PADS        = 32,
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic     [N_PADS-1:0] pad_mux_i,
   input  pad_cfg_t [N_PADS-1:0] pad_cfg_i,
   input  logic                  bypass_i,
   output logic     [N_PADS-1:0] pad_mux_o,
   output pad_cfg_t [N_PADS-1:0] pad_cfg_o,
   output logic     [N_PADS-1:0] pad_gate_o,
   output logic                  busy_o,
   output logic                  done_o
);
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= 2 ** CNT_WIDTH) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1 and < 2**CNT_WIDTH");
   end

   localparam logic [CNT_WIDTH-1:0] RELOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);

   seq_state_e               state_q, state_d;
   logic     [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic     [N_PADS-1:0]    snap_mux_q, snap_mux_d;
   pad_cfg_t [N_PADS-1:0]    snap_cfg_q, snap_cfg_d;
   logic     [N_PADS-1:0]    mask_q, mask_d;
   logic     [N_PADS-1:0]    mux_q, mux_d;
   pad_cfg_t [N_PADS-1:0]    cfg_q, cfg_d;
   logic     [N_PADS-1:0]    gate_q, gate_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic     [N_PADS-1:0]    change;

   pad_change_detect #(.N_PADS(N_PADS)) u_detect (
      .req_mux_i (pad_mux_i),
      .req_cfg_i (pad_cfg_i),
      .cur_mux_i (mux_q),
      .cur_cfg_i (cfg_q),
      .mask_o    (change)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      snap_mux_d = snap_mux_q;
      snap_cfg_d = snap_cfg_q;
      mask_d     = mask_q;
      mux_d      = mux_q;
      cfg_d      = cfg_q;
      done_d     = 1'b0;
      if (bypass_i) begin
         state_d = IDLE;
         mux_d   = pad_mux_i;
         cfg_d   = pad_cfg_i;
      end else begin
         case (state_q)
            IDLE:
               if (|change) begin
                  snap_mux_d = pad_mux_i;
                  snap_cfg_d = pad_cfg_i;
                  mask_d     = change;
                  cnt_d      = RELOAD;
                  state_d    = GATE;
               end
            GATE:
               if (cnt_q == '0) state_d = APPLY;
               else cnt_d = cnt_q - 1'b1;
            APPLY: begin
               mux_d   = snap_mux_q;
               cfg_d   = snap_cfg_q;
               cnt_d   = RELOAD;
               state_d = RELEASE;
            end
            RELEASE:
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else cnt_d = cnt_q - 1'b1;
         endcase
      end
      // Gate and busy are registered from the next state so they track the FSM exactly.
      busy_d = state_d != IDLE;
      gate_d = busy_d ? mask_d : '0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         snap_mux_q <= '0;
         snap_cfg_q <= '0;
         mask_q     <= '0;
         mux_q      <= '0;
         cfg_q      <= '0;
         gate_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         snap_mux_q <= snap_mux_d;
         snap_cfg_q <= snap_cfg_d;
         mask_q     <= mask_d;
         mux_q      <= mux_d;
         cfg_q      <= cfg_d;
         gate_q     <= gate_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign pad_mux_o  = mux_q;
   assign pad_cfg_o  = cfg_q;
   assign pad_gate_o = gate_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
endmodule
